// File: rtl/mem_dp_param_if.sv
// Bus bundle for the dual-port RAM: both request ports plus status.
// Ports (per side A/B): en, rw (1=write), Addr, DataIn, DataOut, valid.
// Shared status: ready (array usable), collision (same-address double write last cycle).
// master = requester side, slave = memory side.
interface mem_dp_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) ();
    logic              enA;
    logic              rwA;
    logic [ADDR_W-1:0] AddrA;
    logic [DATA_W-1:0] DataInA;
    logic [DATA_W-1:0] DataOutA;
    logic              validA;

    logic              enB;
    logic              rwB;
    logic [ADDR_W-1:0] AddrB;
    logic [DATA_W-1:0] DataInB;
    logic [DATA_W-1:0] DataOutB;
    logic              validB;

    logic              ready;
    logic              collision;

    modport master (
        output enA, rwA, AddrA, DataInA,
        output enB, rwB, AddrB, DataInB,
        input  DataOutA, validA, DataOutB, validB, ready, collision
    );

    modport slave (
        input  enA, rwA, AddrA, DataInA,
        input  enB, rwB, AddrB, DataInB,
        output DataOutA, validA, DataOutB, validB, ready, collision
    );
endinterface

// File: rtl/mem_dp_param.sv
// Parametrised true dual-port synchronous RAM with a self-clearing init sweep.
// Ports:
//   clk      - clock, all state on rising edge
//   reset_L  - asynchronous active-low reset
//   bus      - mem_dp_param_if.slave: per-port en/rw/Addr/DataIn requests,
//              registered DataOut + valid strobes, ready and collision status
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clearing array[cnt] to 0 each cycle; requests ignored
// RUN   | array usable; both ports serve reads/writes every cycle
module mem_dp_param #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 3,
    parameter int READ_LAT = 1,
    parameter bit WR_PRIO  = 1'b0,
    parameter bit RDW_NEW  = 1'b0
) (
    input  logic            clk,
    input  logic            reset_L,
    mem_dp_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    // Any READ_LAT other than 2 builds the single-stage pipeline.
    localparam bit LAT2 = (READ_LAT == 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              running;
    logic              rdA, wrA, rdB, wrB, sameAddr;
    logic [DATA_W-1:0] dataRdA, dataRdB;

    logic              s1ValidA, s1ValidB;
    logic [DATA_W-1:0] s1DataA, s1DataB;
    logic              finValidA, finValidB;
    logic [DATA_W-1:0] finDataA, finDataB;

    always_comb begin
        running  = (state == RUN);
        rdA      = running && bus.enA && !bus.rwA;
        wrA      = running && bus.enA &&  bus.rwA;
        rdB      = running && bus.enB && !bus.rwB;
        wrB      = running && bus.enB &&  bus.rwB;
        sameAddr = (bus.AddrA == bus.AddrB);

        // Cross-port read-during-write: forward the other port's write data
        // only when configured for new-data semantics.
        dataRdA = (RDW_NEW && wrB && sameAddr) ? bus.DataInB : mem[bus.AddrA];
        dataRdB = (RDW_NEW && wrA && sameAddr) ? bus.DataInA : mem[bus.AddrB];

        finValidA = LAT2 ? s1ValidA : rdA;
        finDataA  = LAT2 ? s1DataA  : dataRdA;
        finValidB = LAT2 ? s1ValidB : rdB;
        finDataB  = LAT2 ? s1DataB  : dataRdB;
    end

    // Storage has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else begin
            if (wrA && !(wrB && sameAddr && WR_PRIO))
                mem[bus.AddrA] <= bus.DataInA;
            if (wrB && !(wrA && sameAddr && !WR_PRIO))
                mem[bus.AddrB] <= bus.DataInB;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state         <= INIT;
            cnt           <= '0;
            bus.ready     <= 1'b0;
            bus.collision <= 1'b0;
            s1ValidA      <= 1'b0;
            s1ValidB      <= 1'b0;
            s1DataA       <= '0;
            s1DataB       <= '0;
            bus.validA    <= 1'b0;
            bus.validB    <= 1'b0;
            bus.DataOutA  <= '0;
            bus.DataOutB  <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state     <= RUN;
                        bus.ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: state <= INIT;
            endcase

            bus.collision <= wrA && wrB && sameAddr;

            s1ValidA <= rdA;
            s1ValidB <= rdB;
            s1DataA  <= dataRdA;
            s1DataB  <= dataRdB;

            // DataOut holds the last read result across idle/write slots.
            bus.validA <= finValidA;
            bus.validB <= finValidB;
            if (finValidA) bus.DataOutA <= finDataA;
            if (finValidB) bus.DataOutB <= finDataB;
        end
    end
endmodule
